ao486_l15_req_sched: RTL and testbench
======================================

Name: ao486_l15_req_sched

Overview:
- Serialises the three ao486 cache-side memory requesters onto the single L1.5 request port, with one transaction outstanding: readcode (instruction fetch), readline (data line fill) and writeline (dirty line write-back).
- Arbitrates round-robin, drives the L1.5 request header until it is accepted, waits for the matching return, then registers return data and pulses the granted requester's done.
- Sits between the ao486 memory interface and the L1.5. It replaces the edge-detect request logic with an explicit sequencer.

Parameters:
- PHY_ADDR_WIDTH, 40, L1.5 physical address width.
- NC_BIT, 31, ao486 address bit that marks a request non-cacheable.
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- readcode_do  in  1  instruction line request, held until readcode_done
- readcode_address  in  32  fetch address
- readcode_done  out  1  one-cycle completion pulse
- readcode_line  out  128  16B fetched line
- readline_do  in  1  data line read request
- readline_address  in  32  read address
- readline_done  out  1  completion pulse
- readline_line  out  128  16B read line
- writeline_do  in  1  line write request
- writeline_address  in  32  write address
- writeline_line  in  128  write data, little-endian bytes
- writeline_done  out  1  completion pulse
- sched_l15_val  out  1  request valid
- sched_l15_rqtype  out  5  `STORE_RQ / `LOAD_RQ / `IMISS_RQ
- sched_l15_size  out  3  always `PCX_SZ_16B
- sched_l15_address  out  PHY_ADDR_WIDTH  sign-extended {addr[31:4],4'b0}
- sched_l15_nc  out  1  addr[NC_BIT]
- sched_l15_data  out  64  byte-reversed writeline_line[63:0]
- sched_l15_data_next_entry  out  64  byte-reversed writeline_line[127:64]
- l15_sched_ack  in  1  request header accepted
- l15_sched_val  in  1  return valid
- l15_sched_returntype  in  4  return type
- l15_sched_data_0..3  in  64 each  return data
- sched_l15_req_ack  out  1  return consumed; equals l15_sched_val
- sched_busy  out  1  FSM not IDLE
- sched_grant  out  3  one-hot {writeline, readline, readcode} owner

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM is in IDLE.
  - Round-robin pointer selects readcode first.
  - Line registers are 0.
- FSM states: IDLE, ISSUE, WAIT_RESP, RELEASE.
- IDLE:
  - Sample do lines. Pick the first asserted requester at or after the pointer, in the order readcode -> readline -> writeline -> readcode.
  - Latch the grant, address and write data.
  - Go to ISSUE. sched_l15_val rises the next cycle, so request latency is 1 cycle from do.
- ISSUE:
  - sched_l15_val=1. All header fields come from latched state and are stable.
  - On l15_sched_ack: go to WAIT_RESP, and drop val the next cycle.
- WAIT_RESP:
  - Matching returns are `IFILL_RET for readcode, `LOAD_RET for readline, `ST_ACK for writeline.
  - On a matching return, register the line data:
    - readcode_line = addr[4] ? {data_3,data_2} : {data_1,data_0}.
    - readline_line = {data_1,data_0}.
  - Pulse the granted done in the next cycle, with line data valid in that same cycle.
  - Advance the pointer to the requester after the grant. Go to RELEASE.
- Non-matching returns (e.g. `INT_RET) in any state are acked via sched_l15_req_ack and ignored. They do not change state.
- RELEASE:
  - One cycle in which no arbitration takes place, so the served requester's still-high do is not re-granted.
  - Then go to IDLE.
- If a requester drops do mid-transaction, the transaction still completes and done still pulses.
- ack and a return in the same cycle while in ISSUE: treat as ack followed immediately by the return, and go straight to the RELEASE path.
- Line data holds its last value between transactions.
- sched_grant clears in IDLE.
- Reset asserted mid-transaction: immediate return to the reset state. No done is pulsed, and an in-flight L1.5 return after reset is acked and dropped.

Optional Feature:
- Macro: AO486_L15_SCHED_TIMEOUT_EN.
- When defined:
  - A 16-bit counter runs in ISSUE and WAIT_RESP.
  - When it reaches TIMEOUT_CYCLES, the FSM forces done for the granted requester with line data 0, sets a sticky output sched_timeout_err (1 bit, cleared only by reset), and goes to RELEASE.
- When undefined: the port and counter are absent, and the FSM waits indefinitely.

Test Plan:
- readline_do at addr 0x0000_1230, ack after 2 cycles, `LOAD_RET with data_0=0x11..., data_1=0x22... -> val 1 cycle after do; address 0x00_0000_1230; readline_done 1 cycle after return with line {data_1,data_0}.
- writeline_do at addr 0x8000_0040, line bytes 0x00..0x0F -> rqtype `STORE_RQ, nc=1, address 0xFF_8000_0040, data=0x0001020304050607; writeline_done on `ST_ACK.
- readcode_do at addr 0x0000_0010, `IFILL_RET -> readcode_line={data_3,data_2}.
- All three do asserted together, each held until its done -> service order readcode, readline, writeline; exactly one done per transaction; no re-grant during RELEASE.
- `INT_RET injected during WAIT_RESP -> req_ack=1, state unchanged, no done.
- Reset pulsed in WAIT_RESP -> outputs 0 next edge; with AO486_L15_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, a non-responding L1.5 gives done with line 0 and sched_timeout_err=1.

Source files
------------

// File: rtl/ao486_l15_req_sched_if.sv
// Bundle of the ao486 requester ports and the L1.5 request/return port.
// master: the scheduler; slave: the requesters plus the L1.5 side.
interface ao486_l15_req_sched_if #(
  parameter int PHY_ADDR_WIDTH = 40
);
  logic                      readcode_do;
  logic [31:0]               readcode_address;
  logic                      readcode_done;
  logic [127:0]              readcode_line;
  logic                      readline_do;
  logic [31:0]               readline_address;
  logic                      readline_done;
  logic [127:0]              readline_line;
  logic                      writeline_do;
  logic [31:0]               writeline_address;
  logic [127:0]              writeline_line;
  logic                      writeline_done;
  logic                      sched_l15_val;
  logic [4:0]                sched_l15_rqtype;
  logic [2:0]                sched_l15_size;
  logic [PHY_ADDR_WIDTH-1:0] sched_l15_address;
  logic                      sched_l15_nc;
  logic [63:0]               sched_l15_data;
  logic [63:0]               sched_l15_data_next_entry;
  logic                      l15_sched_ack;
  logic                      l15_sched_val;
  logic [3:0]                l15_sched_returntype;
  logic [63:0]               l15_sched_data_0;
  logic [63:0]               l15_sched_data_1;
  logic [63:0]               l15_sched_data_2;
  logic [63:0]               l15_sched_data_3;
  logic                      sched_l15_req_ack;
  logic                      sched_busy;
  logic [2:0]                sched_grant;

  modport master (
    input  readcode_do, readcode_address, readline_do, readline_address,
           writeline_do, writeline_address, writeline_line,
           l15_sched_ack, l15_sched_val, l15_sched_returntype,
           l15_sched_data_0, l15_sched_data_1, l15_sched_data_2, l15_sched_data_3,
    output readcode_done, readcode_line, readline_done, readline_line, writeline_done,
           sched_l15_val, sched_l15_rqtype, sched_l15_size, sched_l15_address,
           sched_l15_nc, sched_l15_data, sched_l15_data_next_entry,
           sched_l15_req_ack, sched_busy, sched_grant
  );

  modport slave (
    output readcode_do, readcode_address, readline_do, readline_address,
           writeline_do, writeline_address, writeline_line,
           l15_sched_ack, l15_sched_val, l15_sched_returntype,
           l15_sched_data_0, l15_sched_data_1, l15_sched_data_2, l15_sched_data_3,
    input  readcode_done, readcode_line, readline_done, readline_line, writeline_done,
           sched_l15_val, sched_l15_rqtype, sched_l15_size, sched_l15_address,
           sched_l15_nc, sched_l15_data, sched_l15_data_next_entry,
           sched_l15_req_ack, sched_busy, sched_grant
  );
endinterface

// File: rtl/ao486_l15_req_sched.sv
// Round-robin sequencer of readcode/readline/writeline onto the L1.5 port, one outstanding.
// Optional watchdog: define AO486_L15_SCHED_TIMEOUT_EN.
//   state       | meaning
//   S_IDLE      | arbitrate do lines, latch winner
//   S_ISSUE     | header valid until l15_sched_ack
//   S_WAIT_RESP | wait for the return type matching the grant
//   S_RELEASE   | one dead cycle so the served do is not re-granted
module ao486_l15_req_sched #(
  parameter int PHY_ADDR_WIDTH = 40,
  parameter int NC_BIT         = 31
`ifdef AO486_L15_SCHED_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic clk,
  input  logic rst_n,
`ifdef AO486_L15_SCHED_TIMEOUT_EN
  output logic sched_timeout_err,
`endif
  ao486_l15_req_sched_if.master bus
);
  localparam logic [4:0] LOAD_RQ    = 5'b00000;
  localparam logic [4:0] IMISS_RQ   = 5'b10000;
  localparam logic [4:0] STORE_RQ   = 5'b00001;
  localparam logic [2:0] PCX_SZ_16B = 3'b111;
  localparam logic [3:0] LOAD_RET   = 4'b0000;
  localparam logic [3:0] IFILL_RET  = 4'b0001;
  localparam logic [3:0] ST_ACK     = 4'b0100;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RESP, S_RELEASE} state_t;

  state_t       state;
  logic [1:0]   rr_ptr;
  logic [2:0]   grant;
  logic [31:4]  addr_q;
  logic [127:0] wline_q;
  logic         val_q;
  logic [2:0]   done_q;
  logic [127:0] rc_line_q;
  logic [127:0] rl_line_q;

  logic [2:0]   do_vec;
  logic [2:0]   pick;
  logic [31:0]  pick_addr;
  logic [1:0]   next_ptr;
  logic         ret_match;
  logic         finish;
  logic         timeout_hit;
  logic [127:0] rc_fill;

  function automatic logic [63:0] byte_swap(input logic [63:0] d);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = d[56-8*i +: 8];
    return r;
  endfunction

  assign do_vec = {bus.writeline_do, bus.readline_do, bus.readcode_do};

  // Rotating priority starting at rr_ptr
  always_comb begin
    pick = 3'b000;
    case (rr_ptr)
      2'd1: begin
        if (do_vec[1])      pick = 3'b010;
        else if (do_vec[2]) pick = 3'b100;
        else if (do_vec[0]) pick = 3'b001;
      end
      2'd2: begin
        if (do_vec[2])      pick = 3'b100;
        else if (do_vec[0]) pick = 3'b001;
        else if (do_vec[1]) pick = 3'b010;
      end
      default: begin
        if (do_vec[0])      pick = 3'b001;
        else if (do_vec[1]) pick = 3'b010;
        else if (do_vec[2]) pick = 3'b100;
      end
    endcase
  end

  always_comb begin
    pick_addr = bus.readcode_address;
    if (pick[1]) pick_addr = bus.readline_address;
    if (pick[2]) pick_addr = bus.writeline_address;
  end

  always_comb begin
    next_ptr = 2'd1;
    if (grant[1]) next_ptr = 2'd2;
    if (grant[2]) next_ptr = 2'd0;
  end

  assign ret_match = bus.l15_sched_val &&
                     ((grant[0] && bus.l15_sched_returntype == IFILL_RET) ||
                      (grant[1] && bus.l15_sched_returntype == LOAD_RET)  ||
                      (grant[2] && bus.l15_sched_returntype == ST_ACK));
  // Ack and return in the same ISSUE cycle complete directly
  assign finish  = ret_match && ((state == S_ISSUE && bus.l15_sched_ack) || state == S_WAIT_RESP);
  assign rc_fill = addr_q[4] ? {bus.l15_sched_data_3, bus.l15_sched_data_2}
                             : {bus.l15_sched_data_1, bus.l15_sched_data_0};

`ifdef AO486_L15_SCHED_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  assign timeout_hit = (state == S_ISSUE || state == S_WAIT_RESP) && tmo_cnt == 16'd0 && !finish;
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= 2'd0;
      grant     <= 3'b000;
      addr_q    <= '0;
      wline_q   <= '0;
      val_q     <= 1'b0;
      done_q    <= 3'b000;
      rc_line_q <= '0;
      rl_line_q <= '0;
`ifdef AO486_L15_SCHED_TIMEOUT_EN
      tmo_cnt           <= '0;
      sched_timeout_err <= 1'b0;
`endif
    end else begin
      done_q <= 3'b000;
      case (state)
        S_IDLE: begin
          if (|pick) begin
            grant   <= pick;
            addr_q  <= pick_addr[31:4];
            wline_q <= bus.writeline_line;
            val_q   <= 1'b1;
            state   <= S_ISSUE;
`ifdef AO486_L15_SCHED_TIMEOUT_EN
            tmo_cnt <= 16'(TIMEOUT_CYCLES - 1);
`endif
          end
        end
        S_ISSUE: begin
          if (bus.l15_sched_ack) begin
            val_q <= 1'b0;
            state <= S_WAIT_RESP;
          end
        end
        S_RELEASE: begin
          grant <= 3'b000;
          state <= S_IDLE;
        end
        default: ;
      endcase
`ifdef AO486_L15_SCHED_TIMEOUT_EN
      if ((state == S_ISSUE || state == S_WAIT_RESP) && tmo_cnt != 16'd0)
        tmo_cnt <= tmo_cnt - 16'd1;
      if (timeout_hit)
        sched_timeout_err <= 1'b1;
`endif
      // Timeout shares the completion path but returns an all-zero line
      if (finish || timeout_hit) begin
        done_q <= grant;
        val_q  <= 1'b0;
        rr_ptr <= next_ptr;
        state  <= S_RELEASE;
        if (grant[0]) rc_line_q <= finish ? rc_fill : '0;
        if (grant[1]) rl_line_q <= finish ? {bus.l15_sched_data_1, bus.l15_sched_data_0} : '0;
      end
    end
  end

  assign bus.readcode_done             = done_q[0];
  assign bus.readline_done             = done_q[1];
  assign bus.writeline_done            = done_q[2];
  assign bus.readcode_line             = rc_line_q;
  assign bus.readline_line             = rl_line_q;
  assign bus.sched_l15_val             = val_q;
  assign bus.sched_l15_rqtype          = grant[2] ? STORE_RQ : (grant[0] ? IMISS_RQ : LOAD_RQ);
  assign bus.sched_l15_size            = (|grant) ? PCX_SZ_16B : 3'b000;
  assign bus.sched_l15_address         = {{(PHY_ADDR_WIDTH-32){addr_q[31]}}, addr_q, 4'b0000};
  assign bus.sched_l15_nc              = addr_q[NC_BIT];
  assign bus.sched_l15_data            = byte_swap(wline_q[63:0]);
  assign bus.sched_l15_data_next_entry = byte_swap(wline_q[127:64]);
  assign bus.sched_l15_req_ack         = bus.l15_sched_val;
  assign bus.sched_busy                = (state != S_IDLE);
  assign bus.sched_grant               = grant;
endmodule

// File: tb/tb_ao486_l15_req_sched.sv
// Self-checking bench: directed plan cases plus randomized traffic against a queue-level model.
// Drives and samples on the falling edge; the DUT acts on the rising edge.
module tb_ao486_l15_req_sched;
  localparam logic [4:0] LOAD_RQ    = 5'b00000;
  localparam logic [4:0] IMISS_RQ   = 5'b10000;
  localparam logic [4:0] STORE_RQ   = 5'b00001;
  localparam logic [2:0] PCX_SZ_16B = 3'b111;
  localparam logic [3:0] LOAD_RET   = 4'b0000;
  localparam logic [3:0] IFILL_RET  = 4'b0001;
  localparam logic [3:0] ST_ACK     = 4'b0100;
  localparam logic [3:0] INT_RET    = 4'b0111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ao486_l15_req_sched_if #(.PHY_ADDR_WIDTH(40)) bus ();
`ifdef AO486_L15_SCHED_TIMEOUT_EN
  logic sched_timeout_err;
  ao486_l15_req_sched #(.PHY_ADDR_WIDTH(40), .NC_BIT(31), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .sched_timeout_err(sched_timeout_err), .bus(bus));
`else
  ao486_l15_req_sched #(.PHY_ADDR_WIDTH(40), .NC_BIT(31)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending set, round-robin index, per-requester address, last lines
  bit   [2:0]   pending = 3'b000;
  int           rr = 0;
  logic [31:0]  m_addr [3];
  logic [127:0] m_wline;
  logic [127:0] m_rc_line = '0;
  logic [127:0] m_rl_line = '0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  function automatic logic [2:0] dones();
    return {bus.writeline_done, bus.readline_done, bus.readcode_done};
  endfunction

  function automatic int model_pick();
    for (int k = 0; k < 3; k++)
      if (pending[(rr + k) % 3]) return (rr + k) % 3;
    return -1;
  endfunction

  task automatic raise(input int i, input logic [31:0] a, input logic [127:0] line);
    pending[i] = 1'b1;
    m_addr[i]  = a;
    case (i)
      0: begin bus.readcode_address = a; bus.readcode_do = 1'b1; end
      1: begin bus.readline_address = a; bus.readline_do = 1'b1; end
      default: begin
        bus.writeline_address = a; bus.writeline_line = line; m_wline = line;
        bus.writeline_do = 1'b1;
      end
    endcase
  endtask

  task automatic drop(input int i);
    pending[i] = 1'b0;
    case (i)
      0: bus.readcode_do = 1'b0;
      1: bus.readline_do = 1'b0;
      default: bus.writeline_do = 1'b0;
    endcase
  endtask

  task automatic drive_ret(input logic [3:0] t, input logic [63:0] d0, d1, d2, d3);
    bus.l15_sched_val = 1'b1;
    bus.l15_sched_returntype = t;
    bus.l15_sched_data_0 = d0; bus.l15_sched_data_1 = d1;
    bus.l15_sched_data_2 = d2; bus.l15_sched_data_3 = d3;
  endtask

  // One full transaction; expects at least one pending requester
  task automatic run_txn(input bit same_cyc, input bit inj_int, input int ack_dly, input int ret_dly,
                         input logic [63:0] d0, d1, d2, d3, output int served);
    int exp;
    bit seen;
    logic [31:0] a;
    logic [63:0] sw0, sw1;
    logic [3:0] rt;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.sched_l15_val) begin seen = 1'b1; break; end
      step();
    end
    chk("val_rise", seen, 1);
    served = -1;
    if (!seen) return;
    exp = model_pick();
    served = exp;
    a = m_addr[exp];
    chk("grant", bus.sched_grant, 3'b001 << exp);
    chk("rqtype", bus.sched_l15_rqtype, exp == 2 ? STORE_RQ : (exp == 0 ? IMISS_RQ : LOAD_RQ));
    chk("size", bus.sched_l15_size, PCX_SZ_16B);
    chk("address", bus.sched_l15_address, {{8{a[31]}}, a[31:4], 4'h0});
    chk("nc", bus.sched_l15_nc, a[31]);
    if (exp == 2) begin
      for (int b = 0; b < 8; b++) begin
        sw0[63-8*b -: 8] = m_wline[8*b +: 8];
        sw1[63-8*b -: 8] = m_wline[64+8*b +: 8];
      end
      chk("wdata", bus.sched_l15_data, sw0);
      chk("wdata_next", bus.sched_l15_data_next_entry, sw1);
    end
    rt = exp == 0 ? IFILL_RET : (exp == 1 ? LOAD_RET : ST_ACK);
    for (int i = 0; i < ack_dly; i++) begin
      step();
      chk("val_hold", bus.sched_l15_val, 1);
    end
    bus.l15_sched_ack = 1'b1;
    if (same_cyc) drive_ret(rt, d0, d1, d2, d3);
    step();
    bus.l15_sched_ack = 1'b0;
    if (!same_cyc) begin
      chk("val_drop", bus.sched_l15_val, 0);
      chk("busy_wait", bus.sched_busy, 1);
      if (inj_int) begin
        drive_ret(INT_RET, d3, d2, d1, d0);
        #1 chk("int_req_ack", bus.sched_l15_req_ack, 1);
        step();
        bus.l15_sched_val = 1'b0;
        chk("int_no_done", dones(), 0);
        chk("int_busy", bus.sched_busy, 1);
      end
      for (int i = 0; i < ret_dly; i++) step();
      drive_ret(rt, d0, d1, d2, d3);
      #1 chk("ret_req_ack", bus.sched_l15_req_ack, 1);
      step();
    end
    bus.l15_sched_val = 1'b0;
    if (exp == 0) m_rc_line = a[4] ? {d3, d2} : {d1, d0};
    if (exp == 1) m_rl_line = {d1, d0};
    chk("done", dones(), 3'b001 << exp);
    chk("rc_line", bus.readcode_line, m_rc_line);
    chk("rl_line", bus.readline_line, m_rl_line);
    drop(exp);
    rr = (exp + 1) % 3;
    step();
    chk("done_single", dones(), 0);
    chk("no_regrant", bus.sched_l15_val, 0);
    chk("grant_clr", bus.sched_grant, 0);
    chk("idle_busy", bus.sched_busy, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    return $urandom;
  endfunction

  function automatic logic [63:0] r64();
    return {$urandom, $urandom};
  endfunction

  int served;
  logic [63:0] q0, q1, q2, q3;

  initial begin
    bus.readcode_do = 0; bus.readcode_address = '0;
    bus.readline_do = 0; bus.readline_address = '0;
    bus.writeline_do = 0; bus.writeline_address = '0; bus.writeline_line = '0;
    bus.l15_sched_ack = 0; bus.l15_sched_val = 0; bus.l15_sched_returntype = '0;
    bus.l15_sched_data_0 = '0; bus.l15_sched_data_1 = '0;
    bus.l15_sched_data_2 = '0; bus.l15_sched_data_3 = '0;
    step(); step();
    chk("rst_val", bus.sched_l15_val, 0);
    chk("rst_busy", bus.sched_busy, 0);
    chk("rst_grant", bus.sched_grant, 0);
    chk("rst_done", dones(), 0);
    chk("rst_rc_line", bus.readcode_line, 0);
    chk("rst_rl_line", bus.readline_line, 0);
    chk("rst_addr", bus.sched_l15_address, 0);
    chk("rst_data", bus.sched_l15_data, 0);
`ifdef AO486_L15_SCHED_TIMEOUT_EN
    chk("rst_tmo_err", sched_timeout_err, 0);
`endif
    rst_n = 1'b1;
    step();

    // Readline at 0x1230 with an interrupt return injected during WAIT_RESP
    raise(1, 32'h0000_1230, '0);
    step();
    chk("latency", bus.sched_l15_val, 1);
    chk("t1_addr", bus.sched_l15_address, 40'h00_0000_1230);
    run_txn(0, 1, 2, 1, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, r64(), r64(), served);
    chk("t1_line", bus.readline_line, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});

    // Non-cacheable writeline with byte-indexed data
    raise(2, 32'h8000_0040, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    step();
    chk("t2_rqtype", bus.sched_l15_rqtype, STORE_RQ);
    chk("t2_nc", bus.sched_l15_nc, 1);
    chk("t2_addr", bus.sched_l15_address, 40'hFF_8000_0040);
    chk("t2_data", bus.sched_l15_data, 64'h0001020304050607);
    run_txn(0, 0, 0, 0, r64(), r64(), r64(), r64(), served);

    // Readcode at 0x10 picks the upper half of the fill
    q0 = r64(); q1 = r64(); q2 = r64(); q3 = r64();
    raise(0, 32'h0000_0010, '0);
    step();
    run_txn(0, 0, 1, 0, q0, q1, q2, q3, served);
    chk("t3_line", bus.readcode_line, {q3, q2});

    // Reset while waiting for the return
    raise(1, 32'h0000_2000, '0);
    step();
    bus.l15_sched_ack = 1'b1;
    step();
    bus.l15_sched_ack = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_val", bus.sched_l15_val, 0);
    chk("mid_rst_busy", bus.sched_busy, 0);
    chk("mid_rst_grant", bus.sched_grant, 0);
    chk("mid_rst_rl_line", bus.readline_line, 0);
    chk("mid_rst_rc_line", bus.readcode_line, 0);
    drop(1);
    rr = 0; m_rc_line = '0; m_rl_line = '0;
    step(); step();
    rst_n = 1'b1;
    drive_ret(LOAD_RET, r64(), r64(), r64(), r64());
    #1 chk("stale_req_ack", bus.sched_l15_req_ack, 1);
    step();
    bus.l15_sched_val = 1'b0;
    chk("stale_no_done", dones(), 0);
    chk("stale_busy", bus.sched_busy, 0);

    // All three together: readcode, readline, writeline in turn
    raise(0, rand_addr(), '0);
    raise(1, rand_addr(), '0);
    raise(2, rand_addr(), {r64(), r64()});
    run_txn(0, 0, 0, 0, r64(), r64(), r64(), r64(), served);
    chk("order0", served, 0);
    run_txn(1, 0, 0, 0, r64(), r64(), r64(), r64(), served);
    chk("order1", served, 1);
    run_txn(0, 1, 1, 2, r64(), r64(), r64(), r64(), served);
    chk("order2", served, 2);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 3; i++)
        if (!pending[i] && $urandom_range(0, 1) == 1) raise(i, rand_addr(), {r64(), r64()});
      if (pending == 3'b000) raise(int'($urandom_range(0, 2)), rand_addr(), {r64(), r64()});
      run_txn($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              r64(), r64(), r64(), r64(), served);
    end
    for (int i = 0; i < 3; i++)
      if (pending[i]) run_txn(0, 0, 0, 0, r64(), r64(), r64(), r64(), served);

`ifdef AO486_L15_SCHED_TIMEOUT_EN
    begin
      bit seen_done;
      seen_done = 1'b0;
      raise(1, rand_addr(), '0);
      step();
      bus.l15_sched_ack = 1'b1;
      step();
      bus.l15_sched_ack = 1'b0;
      for (int i = 0; i < 40 && !seen_done; i++) begin
        step();
        if (bus.readline_done) seen_done = 1'b1;
      end
      chk("tmo_done", seen_done, 1);
      chk("tmo_line", bus.readline_line, 0);
      chk("tmo_err", sched_timeout_err, 1);
      drop(1);
      rr = 2;
      step(); step();
      chk("tmo_err_sticky", sched_timeout_err, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
